tri_bus_arbiter: RTL and testbench
==================================

Name: tri_bus_arbiter

Overview:
- Round-robin arbiter that shares one tristate output bus between NREQ requesters.
- Each requester gets one burst of up to MAX_BURST beats.
- Produces one-hot per-requester tristate drive enables, registered bus data and valid, and a guaranteed dead (turnaround) gap between owners so that two drivers never overlap.
- Sits in front of the pad-level tristate buffers, which are enable-controlled as "en ? data : 'z".

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, bus data width.
- MAX_BURST, 8, maximum beats per grant (1..255).
- TURNAROUND, 1, cycles in TURN state after each burst (1..15).

Ports:
- clk  in  1  single clock, all logic on posedge.
- sreset  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester request; held high while it has beats to send.
- last  in  NREQ  per-requester final-beat flag; qualified by req and gnt.
- wdata  in  NREQ*DW  requester i's data in slice [i*DW +: DW].
- gnt  out  NREQ  registered one-hot grant; a beat occurs in each cycle where gnt[i]&req[i].
- drv_en  out  NREQ  registered one-hot tristate enable, equal to gnt delayed one cycle.
- bus_data  out  DW  registered owner data, updated only on a beat.
- bus_valid  out  1  registered; high the cycle after a beat.
- busy  out  1  high when state is not IDLE.
- burst_trunc  out  1  one-cycle pulse when a burst is ended by MAX_BURST instead of last.

Behaviour:
- Reset: clk and synchronous active-high sreset are already decided.
  - sreset is sampled on posedge clk and overrides everything.
  - Forces state to IDLE and clears gnt, drv_en, bus_valid, busy, burst_trunc and bus_data to 0.
  - Sets the round-robin pointer to NREQ-1, so req[0] has top priority first.
  - Clears the beat counter.
- States: IDLE, OWN, TURN.
- IDLE:
  - If req is not 0, a combinational pick selects the first set bit searching from ptr+1 mod NREQ upward.
  - Next cycle: state OWN, gnt[pick]=1, ptr<=pick, beat counter = 0.
  - If req is 0, stay in IDLE.
- OWN (owner o):
  - req[o]=1 is a beat: bus_data<=wdata[o] and bus_valid<=1 in the next cycle; beat counter increments.
  - The burst ends (gnt<=0, state<=TURN, turnaround counter loaded with TURNAROUND) when any of these holds:
    - the beat has last[o]=1;
    - the beat is number MAX_BURST (burst_trunc pulses the next cycle; if last[o] is also 1, last wins and there is no pulse);
    - req[o]=0, meaning the burst is abandoned, with no beat and no pulse.
  - Requests from other requesters during OWN are ignored; there is no preemption.
- TURN: gnt=0, and state returns to IDLE after TURNAROUND cycles.
- Timing:
  - Between two grants, gnt is all-zero for at least TURNAROUND+1 cycles; drv_en has the same gap.
  - An owner that is the only requester is re-granted after the same gap.
  - Latency from req rising in IDLE to gnt is 1 cycle.
  - Latency from a beat to bus_valid/bus_data is 1 cycle.
  - Latency from gnt to drv_en is 1 cycle.
- last[i] without req[i] or without gnt[i] is ignored.
- bus_data holds its last value when bus_valid=0.
- Invariants for the bench: $onehot0(gnt); $onehot0(drv_en); drv_en is never 1 for two different indices in adjacent cycles.
- Mid-burst sreset: the next cycle shows all outputs 0 and IDLE. The abandoned owner gets no special treatment.

Decomposition:
- Package tri_bus_arb_pkg holds:
  - the state enum (IDLE=2'd0, OWN=2'd1, TURN=2'd2);
  - the clog2 function used to size ptr, the beat counter and the turnaround counter.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req and ptr. Outputs: one-hot pick and index, plus an any flag.

Test Plan:
1. req=0001, wdata0=A1,A2,A3 with last on the 3rd beat -> gnt[0] high cycles 1-3; bus_valid cycles 2-4 with data A1,A2,A3; drv_en[0] cycles 2-4; gnt low cycles 4-5; busy drops at cycle 6.
2. After reset, req=0011 simultaneously, single-beat bursts -> requester 0 granted first, then requester 1 after exactly 2 gnt-low cycles; drv_en[0] and drv_en[1] separated by ≥2 zero cycles.
3. req=0001 held, last never asserted -> exactly 8 beats; burst_trunc one pulse the cycle after beat 8; re-grant to requester 0 after a 2-cycle gap.
4. req=1111 continuous, last=1111 -> grant order 0,1,2,3,0,1; gnt always one-hot.
5. req=0100, sreset asserted for one cycle on the 2nd beat -> next cycle gnt/drv_en/bus_valid/busy all 0; then req=1010 grants requester 1 first.
6. req[2] drops after 2 beats with no last -> burst ends with exactly 2 bus_valid cycles, no burst_trunc, then TURN.

Source files
------------

// File: rtl/tri_bus_arb_pkg.sv
// Shared types and sizing helper for the tristate bus arbiter.
package tri_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from ptr+1, wrapping at NREQ.
module rr_pick
  import tri_bus_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int   best_s;
  int   dist_s;
  logic take_s;

  // Keep the requester with the smallest circular distance past ptr.
  always_comb begin
    pick   = '0;
    idx    = '0;
    any    = 1'b0;
    best_s = NREQ;
    dist_s = 0;
    take_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      dist_s = (i + NREQ - 1 - int'(ptr)) % NREQ;
      take_s = req[i] && (dist_s < best_s);
      if (take_s) begin
        best_s  = dist_s;
        pick    = '0;
        pick[i] = 1'b1;
        idx     = PW'(i);
        any     = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus: one burst per grant,
// a registered pad enable per requester, and a forced dead gap between owners.
module tri_bus_arbiter
  import tri_bus_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DW         = 8,
  parameter int MAX_BURST  = 8,
  parameter int TURNAROUND = 1
) (
  input  logic               clk,
  input  logic               sreset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    last,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    drv_en,
  output logic [DW-1:0]      bus_data,
  output logic               bus_valid,
  output logic               busy,
  output logic               burst_trunc
);

  localparam int PW = clog2(NREQ);
  localparam int BW = clog2(MAX_BURST + 1);
  localparam int TW = clog2(TURNAROUND + 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] drv_en_q, drv_en_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]   turn_cnt_q, turn_cnt_d;
  logic [DW-1:0]   bus_data_q, bus_data_d;
  logic            bus_valid_q, bus_valid_d;
  logic            busy_q, busy_d;
  logic            trunc_q, trunc_d;

  logic [NREQ-1:0] pick_s;
  logic [PW-1:0]   pick_idx_s;
  logic            pick_any_s;
  logic [DW-1:0]   wdata_arr_s [NREQ];
  logic [DW-1:0]   owner_data_s;
  logic            owner_req_s;
  logic            owner_last_s;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick_s),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  // While owning, ptr_q is the owner index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      wdata_arr_s[i] = wdata[i*DW +: DW];
    end
    owner_data_s = wdata_arr_s[ptr_q];
    owner_req_s  = req[ptr_q];
    owner_last_s = last[ptr_q];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    bus_data_d  = bus_data_q;
    bus_valid_d = 1'b0;
    trunc_d     = 1'b0;
    drv_en_d    = gnt_q;
    busy_d      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d    = OWN;
          gnt_d      = pick_s;
          ptr_d      = pick_idx_s;
          beat_cnt_d = '0;
        end else begin
          gnt_d = '0;
        end
      end
      OWN: begin
        if (owner_req_s) begin
          bus_data_d  = owner_data_s;
          bus_valid_d = 1'b1;
          beat_cnt_d  = beat_cnt_q + BW'(1);
          if (owner_last_s || (beat_cnt_q == BW'(MAX_BURST - 1))) begin
            // last wins over the length limit, so no truncation pulse then
            trunc_d    = !owner_last_s;
            gnt_d      = '0;
            state_d    = TURN;
            turn_cnt_d = TW'(TURNAROUND);
          end else begin
            state_d = OWN;
          end
        end else begin
          gnt_d      = '0;
          state_d    = TURN;
          turn_cnt_d = TW'(TURNAROUND);
        end
      end
      TURN: begin
        gnt_d = '0;
        if (turn_cnt_q <= TW'(1)) begin
          state_d = IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      drv_en_q    <= '0;
      ptr_q       <= PW'(NREQ - 1);
      beat_cnt_q  <= '0;
      turn_cnt_q  <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      drv_en_q    <= drv_en_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      bus_data_q  <= bus_data_d;
      bus_valid_q <= bus_valid_d;
      busy_q      <= busy_d;
      trunc_q     <= trunc_d;
    end
  end

  assign gnt         = gnt_q;
  assign drv_en      = drv_en_q;
  assign bus_data    = bus_data_q;
  assign bus_valid   = bus_valid_q;
  assign busy        = busy_q;
  assign burst_trunc = trunc_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter: vector table, directed corner
// sequences and a randomized run against a timestamp-based reference model.
module tb_tri_bus_arbiter;

  localparam int NREQ       = 4;
  localparam int DW         = 8;
  localparam int MAX_BURST  = 8;
  localparam int TURNAROUND = 1;

  logic               clk = 1'b0;
  logic               sreset;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    last;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    drv_en;
  logic [DW-1:0]      bus_data;
  logic               bus_valid;
  logic               busy;
  logic               burst_trunc;

  int checks = 0;
  int errors = 0;

  tri_bus_arbiter #(
    .NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST), .TURNAROUND(TURNAROUND)
  ) dut (
    .clk(clk), .sreset(sreset), .req(req), .last(last), .wdata(wdata),
    .gnt(gnt), .drv_en(drv_en), .bus_data(bus_data), .bus_valid(bus_valid),
    .busy(busy), .burst_trunc(burst_trunc)
  );

  always #5 clk = ~clk;

  // Reference model: owner index, beat count and the cycle from which
  // arbitration is allowed again (end of burst + TURNAROUND + 1).
  int              m_owner, m_beats, m_arb_at, m_ptr, m_cycle;
  logic [NREQ-1:0] e_gnt, e_drv;
  logic            e_valid, e_busy, e_trunc;
  logic [DW-1:0]   e_data;
  logic [NREQ-1:0] prev_drv;

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] l;
    logic [31:0]     wd;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] drv;
    logic            valid;
    logic [DW-1:0]   data;
    logic            busy;
    logic            trunc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic bit_at(input logic [NREQ-1:0] v, input int idx);
    logic [NREQ-1:0] s;
    s = v >> idx;
    return s[0];
  endfunction

  function automatic logic [DW-1:0] slice_of(input logic [NREQ*DW-1:0] v, input int idx);
    logic [NREQ*DW-1:0] s;
    s = v >> (idx * DW);
    return s[DW-1:0];
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (bit_at(v, i)) r = i;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic [NREQ-1:0] r,
                            input logic [NREQ-1:0] l, input logic [NREQ*DW-1:0] wd);
    logic [NREQ-1:0] one;
    one     = {{(NREQ-1){1'b0}}, 1'b1};
    e_busy  = (m_owner >= 0) || (m_cycle < m_arb_at);
    e_drv   = e_gnt;
    e_valid = 1'b0;
    e_trunc = 1'b0;
    if (m_owner >= 0) begin
      if (bit_at(r, m_owner)) begin
        e_valid = 1'b1;
        e_data  = slice_of(wd, m_owner);
        m_beats++;
        if (bit_at(l, m_owner) || m_beats == MAX_BURST) begin
          e_trunc  = !bit_at(l, m_owner);
          m_owner  = -1;
          m_arb_at = m_cycle + TURNAROUND + 1;
        end
      end else begin
        m_owner  = -1;
        m_arb_at = m_cycle + TURNAROUND + 1;
      end
    end else if (m_cycle >= m_arb_at && r != '0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (m_owner < 0 && bit_at(r, (m_ptr + k) % NREQ)) m_owner = (m_ptr + k) % NREQ;
      end
      m_ptr   = m_owner;
      m_beats = 0;
    end
    e_gnt = (m_owner >= 0) ? (one << m_owner) : '0;
    if (rst) begin
      m_owner  = -1;
      m_ptr    = NREQ - 1;
      m_beats  = 0;
      m_arb_at = m_cycle + 1;
      e_gnt    = '0;
      e_drv    = '0;
      e_valid  = 1'b0;
      e_busy   = 1'b0;
      e_trunc  = 1'b0;
      e_data   = '0;
    end
    m_cycle++;
  endtask

  // One clock: drive inputs, advance the model, compare just after the edge.
  task automatic step(input logic rst, input logic [NREQ-1:0] r,
                      input logic [NREQ-1:0] l, input logic [NREQ*DW-1:0] wd);
    logic bad_gap;
    sreset = rst;
    req    = r;
    last   = l;
    wdata  = wd;
    model_step(rst, r, l, wd);
    @(posedge clk);
    #1;
    chk($sformatf("model cyc%0d gnt/drv/vld/data/busy/trunc", m_cycle),
        {gnt, drv_en, bus_valid, bus_data, busy, burst_trunc},
        {e_gnt, e_drv, e_valid, e_data, e_busy, e_trunc});
    chk("gnt_onehot0", {63'd0, $onehot0(gnt)}, 64'd1);
    bad_gap = (prev_drv != '0) && (drv_en != '0) && (prev_drv != drv_en);
    chk("drv_en_adjacent", {63'd0, bad_gap}, 64'd0);
    prev_drv = drv_en;
  endtask

  logic            g_hist [0:20];
  logic            v_hist [0:20];
  logic            t_hist [0:20];
  logic            b_hist [0:20];
  int              order[$];
  int              exp_order [6] = '{0, 1, 2, 3, 0, 1};
  logic [NREQ-1:0] prev_g;
  logic [NREQ-1:0] rr, lr;
  int              nv, nt;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    m_owner = -1; m_beats = 0; m_arb_at = 0; m_ptr = NREQ - 1; m_cycle = 0;
    e_gnt = '0; e_drv = '0; e_valid = 1'b0; e_busy = 1'b0; e_trunc = 1'b0; e_data = '0;
    prev_drv = '0;
    sreset = 1'b1; req = '0; last = '0; wdata = '0;
    #2;

    // Single 3-beat burst, then two requesters back-to-back with one beat each.
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'h0,        4'b0001, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'hA1,       4'b0001, 4'b0001, 1'b1, 8'hA1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'hA2,       4'b0001, 4'b0001, 1'b1, 8'hA2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0001, 4'b0001, 32'hA3,       4'b0000, 4'b0001, 1'b1, 8'hA3, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 1'b0, 8'hA3, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 1'b0, 8'hA3, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0011, 4'b0011, 32'h0000B1B0, 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0011, 4'b0011, 32'h0000B1B0, 4'b0000, 4'b0001, 1'b1, 8'hB0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 32'h0000B1B0, 4'b0000, 4'b0000, 1'b0, 8'hB0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 32'h0000B1B0, 4'b0010, 4'b0000, 1'b0, 8'hB0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 32'h0000B1B0, 4'b0000, 4'b0010, 1'b1, 8'hB1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 1'b0, 8'hB1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 1'b0, 8'hB1, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].r, tbl[i].l, tbl[i].wd);
      chk($sformatf("tbl%0d gnt/drv/vld/data/busy/trunc", i),
          {gnt, drv_en, bus_valid, bus_data, busy, burst_trunc},
          {tbl[i].gnt, tbl[i].drv, tbl[i].valid, tbl[i].data, tbl[i].busy, tbl[i].trunc});
    end

    // Held request, no last: truncated at MAX_BURST, re-granted after the gap.
    step(1'b1, '0, '0, '0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 4'b0001, 4'b0000, {24'h0, 8'(i)});
      g_hist[i] = gnt[0]; v_hist[i] = bus_valid; t_hist[i] = burst_trunc;
    end
    nv = 0; nt = 0;
    for (int i = 1; i <= 10; i++) nv += int'(v_hist[i]);
    for (int i = 1; i <= 12; i++) nt += int'(t_hist[i]);
    chk("trunc_beats", 64'(nv), 64'd8);
    chk("trunc_pulses", 64'(nt), 64'd1);
    chk("trunc_position", {63'd0, t_hist[9]}, 64'd1);
    chk("trunc_regrant_gap", {60'd0, g_hist[8], g_hist[9], g_hist[10], g_hist[11]}, {60'd0, 4'b1001});

    // Everyone requesting single-beat bursts: strict rotation.
    step(1'b1, '0, '0, '0);
    prev_g = gnt;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 4'b1111, 4'b1111, 32'h44332211);
      if (gnt != '0 && prev_g == '0) order.push_back(oh_idx(gnt));
      prev_g = gnt;
    end
    chk("rotation_grants", {63'd0, order.size() >= 6}, 64'd1);
    for (int j = 0; j < 6; j++) begin
      if (j < order.size()) chk($sformatf("rotation_order%0d", j), 64'(order[j]), 64'(exp_order[j]));
    end

    // Reset on the second beat, then priority restarts at requester 0.
    step(1'b1, '0, '0, '0);
    step(1'b0, 4'b0100, 4'b0000, 32'h00C10000);
    step(1'b0, 4'b0100, 4'b0000, 32'h00C20000);
    step(1'b1, 4'b0100, 4'b0000, 32'h00C30000);
    chk("midreset_outputs", {gnt, drv_en, bus_valid, bus_data, busy, burst_trunc}, 64'd0);
    step(1'b0, 4'b1010, 4'b0000, 32'h0);
    chk("midreset_regrant", 64'(gnt), 64'(4'b0010));

    // Owner drops its request after two beats: abandoned burst.
    step(1'b1, '0, '0, '0);
    step(1'b0, 4'b0100, 4'b0000, 32'h0);
    for (int i = 2; i <= 6; i++) begin
      step(1'b0, (i <= 3) ? 4'b0100 : 4'b0000, 4'b0000, {8'h0, 8'(8'h60 + i), 16'h0});
      v_hist[i] = bus_valid; t_hist[i] = burst_trunc; b_hist[i] = busy; g_hist[i] = gnt[2];
    end
    nv = 0; nt = 0;
    for (int i = 2; i <= 6; i++) begin
      nv += int'(v_hist[i]);
      nt += int'(t_hist[i]);
    end
    chk("abandon_beats", 64'(nv), 64'd2);
    chk("abandon_no_trunc", 64'(nt), 64'd0);
    chk("abandon_gnt_drop", {63'd0, g_hist[4]}, 64'd0);
    chk("abandon_busy_turn", {61'd0, b_hist[4], b_hist[5], b_hist[6]}, {61'd0, 3'b110});

    // Randomized traffic against the model, with occasional resets.
    rr = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) rr = NREQ'($urandom);
      lr = NREQ'($urandom) & NREQ'($urandom);
      step(($urandom_range(0, 199) == 0), rr, lr, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
